// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and parameter legality check for multimode_counter
package counter_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic bit params_ok(input int width, input longint unsigned max,
                                   input int prescale);
    bit ok;
    ok = (width >= 2) && (width <= 32);
    ok = ok && (max >= 64'd1) && (max < (64'd1 << width));
    ok = ok && (prescale >= 1) && (prescale <= 65535);
    return ok;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - enable prescaler producing one step every PRESCALE enabled cycles
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic step
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] phase;

  assign step = en && (phase == LAST);

  // en=0 freezes the phase; only reset or clear discard it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (en) begin
      phase <= step ? 16'd0 : phase + 16'd1;
    end
  end

endmodule

// File: rtl/multimode_counter.sv
// rtl/multimode_counter.sv - prescaled up/down wrap/saturate counter with load, tc and sticky ovf
module multimode_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX      = (64'd1 << WIDTH) - 64'd1,
  parameter int              PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             up,
  input  logic             sat,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  if (!params_ok(WIDTH, MAX, PRESCALE)) begin : g_bad_params
    $error("multimode_counter: illegal WIDTH/MAX/PRESCALE");
  end

  localparam logic [WIDTH:0] MAX_X = MAX[WIDTH:0];

  logic           step;
  logic           bound;
  logic           event_hit;
  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] nxt_x;
  logic [WIDTH:0] data_x;
  logic [WIDTH:0] load_x;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clear (load),
    .step  (step)
  );

  // one extra bit keeps +1 at MAX = 2**WIDTH-1 from truncating
  always_comb begin
    cnt_x = {1'b0, out};
    nxt_x = cnt_x;
    bound = 1'b0;
    if (up == DIR_UP) begin
      if (cnt_x >= MAX_X) begin
        bound = 1'b1;
        nxt_x = (sat == MODE_SAT) ? MAX_X : '0;
      end else begin
        nxt_x = cnt_x + 1'b1;
      end
    end else begin
      if (cnt_x == '0) begin
        bound = 1'b1;
        nxt_x = (sat == MODE_SAT) ? '0 : MAX_X;
      end else begin
        nxt_x = cnt_x - 1'b1;
      end
    end
  end

  assign data_x    = {1'b0, data};
  assign load_x    = (data_x > MAX_X) ? MAX_X : data_x;
  assign event_hit = !load && step && bound;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (load) begin
        out <= load_x[WIDTH-1:0];
      end else if (step) begin
        out <= nxt_x[WIDTH-1:0];
      end
      tc  <= event_hit;
      ovf <= event_hit || (ovf && !clr_ovf);
    end
  end

endmodule

// File: tb/tb_multimode_counter.sv
// tb/tb_multimode_counter.sv - randomized/directed check of three multimode_counter configurations
module tb_multimode_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, load = 1'b0, up = 1'b1, sat = 1'b0, clr_ovf = 1'b0;
  logic [7:0] data = 8'd0;
  logic [7:0] out0, out1;
  logic [3:0] out2;
  logic       tc0, tc1, tc2, ovf0, ovf1, ovf2;

  int compared = 0;
  int mismatched = 0;

  int m_out[3], m_pre[3];
  bit m_tc[3], m_ovf[3];
  int mx[3]    = '{9, 9, 15};
  int ps[3]    = '{1, 4, 1};
  int dmask[3] = '{255, 255, 15};

  always #5 clk = ~clk;

  multimode_counter #(.WIDTH(8), .MAX(9), .PRESCALE(1)) d0 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .up(up), .sat(sat),
    .clr_ovf(clr_ovf), .out(out0), .tc(tc0), .ovf(ovf0));
  multimode_counter #(.WIDTH(8), .MAX(9), .PRESCALE(4)) d1 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data), .up(up), .sat(sat),
    .clr_ovf(clr_ovf), .out(out1), .tc(tc1), .ovf(ovf1));
  multimode_counter #(.WIDTH(4), .MAX(15), .PRESCALE(1)) d2 (
    .clk(clk), .rst(rst), .en(en), .load(load), .data(data[3:0]), .up(up), .sat(sat),
    .clr_ovf(clr_ovf), .out(out2), .tc(tc2), .ovf(ovf2));

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_out[i] = 0; m_pre[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end
  endtask

  // Behavioural rules: count modulo MAX+1 or clamp, prescaler as enabled-cycle counter
  task automatic model_edge();
    bit stepped, boundary;
    int d;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      boundary = 0;
      if (load) begin
        d = int'(data) & dmask[i];
        m_out[i] = (d > mx[i]) ? mx[i] : d;
        m_pre[i] = 0;
      end else begin
        stepped = en && (m_pre[i] == ps[i] - 1);
        if (en) m_pre[i] = (m_pre[i] + 1) % ps[i];
        if (stepped) begin
          if (up) begin
            boundary = (m_out[i] == mx[i]);
            m_out[i] = boundary ? (sat ? mx[i] : 0) : m_out[i] + 1;
          end else begin
            boundary = (m_out[i] == 0);
            m_out[i] = boundary ? (sat ? 0 : mx[i]) : m_out[i] - 1;
          end
        end
      end
      m_tc[i]  = boundary;
      m_ovf[i] = boundary ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf[i]);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".out0"}, int'(out0), m_out[0]);
    chk({ph, ".tc0"},  int'(tc0),  int'(m_tc[0]));
    chk({ph, ".ovf0"}, int'(ovf0), int'(m_ovf[0]));
    chk({ph, ".out1"}, int'(out1), m_out[1]);
    chk({ph, ".tc1"},  int'(tc1),  int'(m_tc[1]));
    chk({ph, ".ovf1"}, int'(ovf1), int'(m_ovf[1]));
    chk({ph, ".out2"}, int'(out2), m_out[2]);
    chk({ph, ".tc2"},  int'(tc2),  int'(m_tc[2]));
    chk({ph, ".ovf2"}, int'(ovf2), int'(m_ovf[2]));
  endtask

  task automatic tick(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset.out0", int'(out0), 0);
    chk("reset.tc0",  int'(tc0), 0);
    chk("reset.ovf0", int'(ovf0), 0);
    rst = 1'b0;

    en = 1; up = 1; sat = 0;
    repeat (25) tick("wrap_up");
    chk("wrap_up.final_out0", int'(out0), 5);
    chk("wrap_up.final_ovf0", int'(ovf0), 1);
    chk("wrap_up.final_out1", int'(out1), 6);

    load = 1; data = 0; tick("load0");
    load = 0; up = 0;
    repeat (3) tick("wrap_down");
    chk("wrap_down.out0", int'(out0), 7);
    load = 1; data = 0; tick("load0b");
    load = 0; sat = 1;
    repeat (4) tick("sat_low");
    chk("sat_low.out0", int'(out0), 0);
    chk("sat_low.tc0", int'(tc0), 1);

    load = 1; data = 0; sat = 0; up = 1; tick("load0c");
    load = 0;
    repeat (12) tick("pre_run");
    chk("pre_run.out1", int'(out1), 3);
    en = 0; repeat (3) tick("pre_hold");
    en = 1; repeat (3) tick("pre_resume");
    chk("pre_resume.out1_before", int'(out1), 3);
    tick("pre_resume4");
    chk("pre_resume.out1_after", int'(out1), 4);

    load = 1; data = 200; tick("load_clamp");
    chk("load_clamp.out0", int'(out0), 9);
    chk("load_clamp.out2", int'(out2), 8);
    data = 5; tick("load_over_step");
    chk("load_over_step.out0", int'(out0), 5);
    chk("load_over_step.tc0", int'(tc0), 0);

    data = 9; tick("load9");
    load = 0; clr_ovf = 1; tick("clr_vs_wrap");
    chk("clr_vs_wrap.ovf0", int'(ovf0), 1);
    en = 0; tick("clr_alone");
    chk("clr_alone.ovf0", int'(ovf0), 0);
    clr_ovf = 0;

    load = 1; data = 6; tick("load6");
    load = 0; en = 1;
    #2 rst = 1;
    #1;
    model_reset();
    chk("async_rst.out0", int'(out0), 0);
    chk("async_rst.tc0", int'(tc0), 0);
    chk("async_rst.ovf0", int'(ovf0), 0);
    tick("rst_held");
    #2 rst = 0;
    tick("after_rst");
    chk("after_rst.out0", int'(out0), 1);

    load = 1; data = 14; tick("load14");
    load = 0;
    repeat (3) tick("w4_wrap");

    for (int n = 0; n < 400; n++) begin
      en      = ($urandom_range(0, 9) < 8);
      load    = ($urandom_range(0, 15) == 0);
      data    = 8'($urandom);
      up      = 1'($urandom);
      sat     = 1'($urandom);
      clr_ovf = ($urandom_range(0, 7) == 0);
      tick("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
